// File: rtl/surf4_hk_poller.sv
// Housekeeping poller: on each rising trigger edge, reads a window of WISHBONE
// registers one at a time and copies every word into the housekeeping buffer.
module surf4_hk_poller #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [19:0] base_adr_i,
  input  logic [7:0]  count_i,
  output logic        wbmc_cyc_o,
  output logic        wbmc_stb_o,
  output logic        wbmc_we_o,
  output logic [19:0] wbmc_adr_o,
  output logic [31:0] wbmc_dat_o,
  output logic [3:0]  wbmc_sel_o,
  input  logic [31:0] wbmc_dat_i,
  input  logic        wbmc_ack_i,
  input  logic        wbmc_err_i,
  input  logic        wbmc_rty_i,
  output logic        buf_we_o,
  output logic [7:0]  buf_adr_o,
  output logic [31:0] buf_dat_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        missed_o,
  output logic [7:0]  err_cnt_o
);

  // WISHBONE handshake: a read is one cyc/stb assertion held until the first
  // cycle where ack, err or rty is sampled high (ack has priority), or until
  // the stb has been high for TIMEOUT cycles; cyc always drops between reads.

  typedef enum logic [1:0] {IDLE, REQ, STORE, DONE} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        start_q;
  logic        start_edge;
  logic [17:0] base_q;
  logic [7:0]  count_q;
  logic [7:0]  idx_q;
  logic [31:0] word_q;
  logic [15:0] tmo_q;
  logic [7:0]  err_cnt_q;
  logic        missed_q;
  logic        resp_err;
  logic        timeout_hit;
  logic        last_word;

  assign start_edge  = start_i & ~start_q;
  assign resp_err    = wbmc_err_i | wbmc_rty_i;
  assign timeout_hit = ~wbmc_ack_i & ~resp_err & (tmo_q == TMO_LAST);
  assign last_word   = (idx_q == count_q - 8'd1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    wbmc_cyc_o = 1'b0;
    wbmc_stb_o = 1'b0;
    buf_we_o   = 1'b0;
    done_o     = 1'b0;
    busy_o     = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start_edge) state_d = (count_i == 8'd0) ? DONE : REQ;
      end
      REQ: begin
        wbmc_cyc_o = 1'b1;
        wbmc_stb_o = 1'b1;
        if (wbmc_ack_i || resp_err || timeout_hit) state_d = STORE;
      end
      STORE: begin
        buf_we_o = 1'b1;
        state_d  = last_word ? DONE : REQ;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      start_q   <= 1'b1;
      base_q    <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      tmo_q     <= '0;
      err_cnt_q <= '0;
      missed_q  <= 1'b0;
    end else begin
      start_q  <= start_i;
      missed_q <= start_edge && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (start_edge) begin
            base_q    <= base_adr_i[19:2];
            count_q   <= count_i;
            idx_q     <= '0;
            err_cnt_q <= '0;
            tmo_q     <= '0;
          end
        end
        REQ: begin
          if (wbmc_ack_i) begin
            word_q <= wbmc_dat_i;
            tmo_q  <= '0;
          end else if (resp_err || timeout_hit) begin
            word_q <= ERR_WORD;
            tmo_q  <= '0;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        STORE: begin
          if (!last_word) idx_q <= idx_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Word address wraps modulo 2^18 through the 18-bit sum.
  assign wbmc_adr_o = {base_q + {10'd0, idx_q}, 2'b00};
  assign wbmc_we_o  = 1'b0;
  assign wbmc_dat_o = '0;
  assign wbmc_sel_o = 4'hF;
  assign buf_adr_o  = idx_q;
  assign buf_dat_o  = word_q;
  assign missed_o   = missed_q;
  assign err_cnt_o  = err_cnt_q;

endmodule
